// File: rtl/mdu_alu.sv
// Handshaked integer ALU with iterative RV32M multiply/divide (one bit per cycle).
// Optional macro MDU_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero finish in one cycle.
module mdu_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SRA = 5'd3;
    localparam logic [4:0] OP_SRL = 5'd4,  OP_OR  = 5'd5,  OP_XOR = 5'd6,  OP_SLT = 5'd7;
    localparam logic [4:0] OP_SLTU = 5'd8, OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state;
    logic [SHW-1:0]      count;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     rem;
    logic                neg_q;
    logic                neg_r;
    logic                sel_alt;

    function automatic logic [XLEN-1:0] base_op(input logic [4:0] f,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
        logic signed [XLEN-1:0] sx;
        logic signed [XLEN-1:0] sy;
        sx = x;
        sy = y;
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLL:  return x << y[SHW-1:0];
            OP_SRA:  return sx >>> y[SHW-1:0];
            OP_SRL:  return x >> y[SHW-1:0];
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SLT:  return {{(XLEN-1){1'b0}}, sx < sy};
            OP_SLTU: return {{(XLEN-1){1'b0}}, x < y};
            OP_AND:  return x & y;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    logic is_mul, is_div, a_signed, b_signed;
    assign is_mul = (op >= OP_MUL) && (op <= OP_MULHU);
    assign is_div = (op >= OP_DIV) && (op <= OP_REMU);

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
    end

    logic            early;
    logic [XLEN-1:0] early_res;
`ifdef MDU_EARLY_OUT_EN
    assign early     = (is_mul && (a == '0 || b == '0)) || (is_div && b == '0);
    assign early_res = is_mul ? '0 : ((op == OP_DIV || op == OP_DIVU) ? '1 : a);
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // Shift-add multiply step: multiplier bits consumed LSB first from mag_b
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt, mul_fin;
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (mag_b[0] ? {1'b0, mag_a} : '0);
    assign prod_nxt = {mul_sum, prod[XLEN-1:1]};
    assign mul_fin  = neg_q ? -prod_nxt : prod_nxt;

    // Restoring divide step: dividend shifts out of mag_a MSB while quotient bits shift in
    logic [XLEN:0]   div_sh, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin, step_res;
    assign div_sh   = {rem, mag_a[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mag_b};
    assign div_ge   = ~div_diff[XLEN];
    assign rem_nxt  = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign quo_nxt  = {mag_a[XLEN-2:0], div_ge};
    assign quo_fin  = neg_q ? -quo_nxt : quo_nxt;
    assign rem_fin  = neg_r ? -rem_nxt : rem_nxt;
    assign step_res = (state == MUL) ? (sel_alt ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0])
                                     : (sel_alt ? rem_fin : quo_fin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            prod    <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_alt <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if ((is_mul || is_div) && !early) begin
                        mag_a   <= magnitude(a, a_signed);
                        mag_b   <= magnitude(b, b_signed);
                        prod    <= '0;
                        rem     <= '0;
                        count   <= '0;
                        // Divide-by-zero keeps an all-ones quotient regardless of operand signs
                        neg_q   <= is_mul ? ((a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]))
                                          : (a_signed & (a[XLEN-1] ^ b[XLEN-1]) & (b != '0));
                        neg_r   <= a_signed & a[XLEN-1];
                        sel_alt <= is_mul ? (op != OP_MUL) : (op == OP_REM || op == OP_REMU);
                        state   <= is_mul ? MUL : DIV;
                    end else begin
                        result <= early ? early_res : base_op(op, a, b);
                        state  <= DONE;
                    end
                end
                MUL: begin
                    prod  <= prod_nxt;
                    mag_b <= mag_b >> 1;
                    count <= count + 1'b1;
                    if (count == SHW'(XLEN-1)) begin
                        result <= step_res;
                        state  <= DONE;
                    end
                end
                DIV: begin
                    rem   <= rem_nxt;
                    mag_a <= quo_nxt;
                    count <= count + 1'b1;
                    if (count == SHW'(XLEN-1)) begin
                        result <= step_res;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DIV);
endmodule
